// File: rtl/alu_ctrl_muldiv.sv
// ALU-control decoder plus an iterative RV32M multiply/divide sequencer that stalls the pipeline.
// Optional macro ALU_CTRL_MULDIV_FAST_MUL_EN: MUL* through a single-cycle multiplier instead of shift-add.
module alu_ctrl_muldiv #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              stall_o,
    output logic              md_sel_o,
    output logic [XLEN-1:0]   md_result_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_XOR  = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SLL  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_SRL  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALU_SRA  = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALU_SLTU = CTRL_W'(9);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d, negr_q, negr_d;

    logic              start;
    logic              sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     macc;
    logic [XLEN+1:0]   dtrial;
    logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;
    logic              unused_ok;

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op[1:0])
            2'd0: alu_ctrl_o = ALU_ADD;
            2'd1: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctrl_o = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_o = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl_o = ALU_SLTU;
                    default:        alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: begin
                case (funct3)
                    // I-type ADDI has no SUB form, so funct7_5 only matters for R-type
                    3'b000:  alu_ctrl_o = (!alu_op[0] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
        endcase
    end

    assign start = rst_n & valid_i & (alu_op[1:0] == 2'd2) & funct7_0 & (state_q == S_IDLE) & ~flush_i;

    always_comb begin
        if (funct3[2]) begin
            sa = ~funct3[0] & rs1_i[XLEN-1];
            sb = ~funct3[0] & rs2_i[XLEN-1];
        end else begin
            sa = ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10)) & rs1_i[XLEN-1];
            sb = (funct3[1:0] == 2'b01) & rs2_i[XLEN-1];
        end
        mag_a    = sa ? -rs1_i : rs1_i;
        mag_b    = sb ? -rs2_i : rs2_i;
        div_zero = (rs2_i == '0);
        div_ovf  = ~funct3[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    end

    // One shift-add / restore-subtract step; hi holds partial product or remainder.
    always_comb begin
        macc   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi = macc[XLEN:1];
        mul_lo = {macc[0], lo_q[XLEN-1:1]};
        dtrial = {1'b0, hi_q, lo_q[XLEN-1]} - {2'b00, opnd_q};
        if (dtrial[XLEN+1]) begin
            div_hi = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            div_lo = {lo_q[XLEN-2:0], 1'b0};
        end else begin
            div_hi = dtrial[XLEN-1:0];
            div_lo = {lo_q[XLEN-2:0], 1'b1};
        end
        prod_fix = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
        quo_fix  = neg_q ? -div_lo : div_lo;
        rem_fix  = negr_q ? -div_hi : div_hi;
    end

`ifdef ALU_CTRL_MULDIV_FAST_MUL_EN
    logic [2*XLEN+1:0] fa, fb, fprod;
    assign fa        = {{(XLEN+2){sa}}, rs1_i};
    assign fb        = {{(XLEN+2){sb}}, rs2_i};
    assign fprod     = fa * fb;
    assign unused_ok = ^{alu_op[3:2], f3_q[2], dtrial[XLEN], fprod[2*XLEN+1:2*XLEN]};
`else
    assign unused_ok = ^{alu_op[3:2], f3_q[2], dtrial[XLEN]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d   = funct3;
                    cnt_d  = CNT_W'(XLEN);
                    hi_d   = '0;
                    neg_d  = sa ^ sb;
                    negr_d = sa;
                    if (!funct3[2]) begin
`ifdef ALU_CTRL_MULDIV_FAST_MUL_EN
                        res_d   = (funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
                        state_d = S_DONE;
`else
                        opnd_d  = mag_a;
                        lo_d    = mag_b;
                        state_d = S_MUL;
`endif
                    end else if (div_zero) begin
                        res_d   = funct3[1] ? rs1_i : '1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        res_d   = funct3[1] ? '0 : rs1_i;
                        state_d = S_DONE;
                    end else begin
                        opnd_d  = mag_b;
                        lo_d    = mag_a;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end
            end
            S_DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = f3_q[1] ? rem_fix : quo_fix;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_comb begin
        stall_o     = start | (state_q == S_MUL) | (state_q == S_DIV);
        md_sel_o    = (state_q == S_DONE);
        md_result_o = (state_q == S_DONE) ? res_q : '0;
    end
endmodule
